// File: rtl/mux_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_shift_reg_pkg
// Description : Operation and control-state encodings for mux_shift_reg.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage : mux_shift_reg_pkg
`default_nettype wire

// File: rtl/mux_dff_cell.sv
`default_nettype none
// ============================================================================
// Module      : mux_dff_cell
// Description : One register bit: 8:1 operation mux feeding an async-reset DFF.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_dff_cell
    import mux_shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sel,
    input  logic       d,
    input  logic       shl_in,
    input  logic       shr_in,
    input  logic       rol_in,
    input  logic       ror_in,
    input  logic       asr_in,
    output logic       q
);

    logic r_q;
    logic w_next;

    always_comb begin
        w_next = r_q;
        case (sel)
            MODE_HOLD:  w_next = r_q;
            MODE_LOAD:  w_next = d;
            MODE_SHL:   w_next = shl_in;
            MODE_SHR:   w_next = shr_in;
            MODE_ROL:   w_next = rol_in;
            MODE_ROR:   w_next = ror_in;
            MODE_ASR:   w_next = asr_in;
            MODE_CLEAR: w_next = 1'b0;
            default:    w_next = r_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule : mux_dff_cell
`default_nettype wire

// File: rtl/mux_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_shift_reg
// Description : WIDTH-bit mux-cell register with single ops and burst shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_shift_reg
    import mux_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] c_zero = '0;
    localparam logic [AMT_W-1:0] c_one  = AMT_W'(1);

    state_e           r_state;
    logic [AMT_W-1:0] r_rem;
    logic [2:0]       r_burst_mode;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_q;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_shl, w_shr, w_rol, w_ror, w_asr;

    // Operation applied to every cell this edge; HOLD whenever no op is due.
    always_comb begin
        w_op = MODE_HOLD;
        if (r_state == ST_BUSY) begin
            w_op = r_burst_mode;
        end else if (start) begin
            w_op = (amt == c_zero) ? 3'(MODE_HOLD) : mode;
        end else if (en) begin
            w_op = mode;
        end
    end

    assign w_shl = {w_q[WIDTH-2:0], sin_lsb};
    assign w_shr = {sin_msb, w_q[WIDTH-1:1]};
    assign w_rol = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
    assign w_ror = {w_q[0], w_q[WIDTH-1:1]};
    assign w_asr = {w_q[WIDTH-1], w_q[WIDTH-1:1]};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            mux_dff_cell u_cell (
                .clk    (clk),
                .rst    (rst),
                .sel    (w_op),
                .d      (d[i]),
                .shl_in (w_shl[i]),
                .shr_in (w_shr[i]),
                .rol_in (w_rol[i]),
                .ror_in (w_ror[i]),
                .asr_in (w_asr[i]),
                .q      (w_q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rem        <= c_zero;
            r_burst_mode <= MODE_HOLD;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_burst_mode <= mode;
                        // First op lands on this edge, so only amt-1 remain.
                        if (amt <= c_one) begin
                            r_rem  <= c_zero;
                            r_done <= 1'b1;
                        end else begin
                            r_rem   <= amt - c_one;
                            r_state <= ST_BUSY;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    r_rem <= r_rem - c_one;
                    if (r_rem == c_one) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q        = w_q;
    assign sout_msb = w_q[WIDTH-1];
    assign sout_lsb = w_q[0];
    assign busy     = r_busy;
    assign done     = r_done;

endmodule : mux_shift_reg
`default_nettype wire

// File: tb/tb_mux_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_shift_reg
// Description : Scoreboard bench for mux_shift_reg (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_shift_reg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    localparam logic [2:0] c_hold = 3'b000, c_load = 3'b001, c_shl = 3'b010,
        c_shr = 3'b011, c_rol = 3'b100, c_ror = 3'b101, c_asr = 3'b110,
        c_clear = 3'b111;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [AMT_W-1:0] amt = '0;
    logic [WIDTH-1:0] d = '0;
    logic             sin_lsb = 1'b0;
    logic             sin_msb = 1'b0;
    logic [WIDTH-1:0] q;
    logic             sout_msb, sout_lsb, busy, done;

    mux_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .mode     (mode),
        .amt      (amt),
        .d        (d),
        .sin_lsb  (sin_lsb),
        .sin_msb  (sin_msb),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int busy_seen = 0;
    int done_seen = 0;

    // Reference model state
    logic [WIDTH-1:0] m_q = '0;
    logic             m_busy_st = 1'b0;
    logic             m_done = 1'b0;
    int               m_rem = 0;
    logic [2:0]       m_bmode = 3'b000;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                                   input logic sl, input logic sm);
        case (m)
            c_hold:  return v;
            c_load:  return d;
            c_shl:   return {v[WIDTH-2:0], sl};
            c_shr:   return {sm, v[WIDTH-1:1]};
            c_rol:   return {v[WIDTH-2:0], v[WIDTH-1]};
            c_ror:   return {v[0], v[WIDTH-1:1]};
            c_asr:   return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return '0;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0] op;
        op = c_hold;
        m_done = 1'b0;
        if (m_busy_st) begin
            op = m_bmode;
            if (m_rem == 1) begin
                m_busy_st = 1'b0;
                m_done    = 1'b1;
            end
            m_rem--;
        end else if (start) begin
            m_bmode = mode;
            if (amt == 0) begin
                m_done = 1'b1;
            end else begin
                op = mode;
                if (amt == 1) m_done = 1'b1;
                else begin
                    m_busy_st = 1'b1;
                    m_rem     = int'(amt) - 1;
                end
            end
        end else if (en) begin
            op = mode;
        end
        m_q = apply_op(op, m_q, sin_lsb, sin_msb);
    endtask

    task automatic model_reset();
        m_q = '0; m_busy_st = 1'b0; m_done = 1'b0; m_rem = 0; m_bmode = c_hold;
        sb.delete();
    endtask

    // Drive one cycle of inputs, predict, then compare after the edge.
    task automatic step(input logic e, input logic s, input logic [2:0] m,
                        input logic [AMT_W-1:0] a, input logic [WIDTH-1:0] dv,
                        input logic sl, input logic sm);
        exp_t x;
        en = e; start = s; mode = m; amt = a; d = dv; sin_lsb = sl; sin_msb = sm;
        model_step();
        sb.push_back('{q: m_q, busy: m_busy_st, done: m_done});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("q", 32'(q), 32'(x.q));
        check("busy", 32'(busy), 32'(x.busy));
        check("done", 32'(done), 32'(x.done));
        check("sout", {30'd0, sout_msb, sout_lsb}, {30'd0, x.q[WIDTH-1], x.q[0]});
        if (busy) busy_seen++;
        if (done) done_seen++;
        en = 1'b0; start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, c_hold, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset_q", 32'(q), 0);

        // 1: async reset in the middle of a ROL burst
        step(1, 0, c_load, 0, 8'h81, 0, 0);
        step(0, 1, c_rol, 5, 0, 0, 0);
        idle(1);
        check("t1_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("t1_rst_q", 32'(q), 0);
        check("t1_rst_busy", 32'(busy), 0);
        check("t1_rst_done", 32'(done), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        check("t1_after_q", 32'(q), 0);

        // 2: single ops
        done_seen = 0;
        step(1, 0, c_load, 0, 8'hA5, 0, 0);
        check("t2_load", 32'(q), 32'hA5);
        step(1, 0, c_asr, 0, 0, 0, 0);
        check("t2_asr", 32'(q), 32'hD2);
        step(1, 0, c_shr, 0, 0, 0, 0);
        check("t2_shr", 32'(q), 32'h69);
        check("t2_no_done", 32'(done_seen), 0);

        // 3: ROL burst of 3
        step(1, 0, c_load, 0, 8'hA5, 0, 0);
        busy_seen = 0; done_seen = 0;
        step(0, 1, c_rol, 3, 0, 0, 0);
        check("t3_op1", 32'(q), 32'h4B);
        idle(1);
        check("t3_op2", 32'(q), 32'h96);
        idle(1);
        check("t3_op3", 32'(q), 32'h2D);
        idle(2);
        check("t3_busy_cycles", 32'(busy_seen), 2);
        check("t3_done_cycles", 32'(done_seen), 1);
        check("t3_final", 32'(q), 32'h2D);

        // 4: requests during a burst are ignored; ASR x8
        step(1, 0, c_load, 0, 8'hA5, 0, 0);
        step(0, 1, c_rol, 3, 0, 0, 0);
        step(1, 1, c_clear, 7, 8'h00, 0, 0);
        step(1, 1, c_clear, 7, 8'h00, 0, 0);
        idle(1);
        check("t4_ignore", 32'(q), 32'h2D);
        step(1, 0, c_load, 0, 8'h80, 0, 0);
        done_seen = 0;
        step(0, 1, c_asr, 8, 0, 0, 0);
        idle(8);
        check("t4_asr8", 32'(q), 32'hFF);
        check("t4_done", 32'(done_seen), 1);

        // 5: edge amounts
        step(1, 0, c_load, 0, 8'h2D, 0, 0);
        busy_seen = 0; done_seen = 0;
        step(0, 1, c_rol, 0, 0, 0, 0);
        idle(2);
        check("t5_amt0_q", 32'(q), 32'h2D);
        check("t5_amt0_done", 32'(done_seen), 1);
        check("t5_amt0_busy", 32'(busy_seen), 0);
        step(1, 0, c_clear, 0, 0, 0, 0);
        step(0, 1, c_shl, 1, 0, 1, 0);
        check("t5_amt1_q", 32'(q), 32'h01);
        check("t5_amt1_busy", 32'(busy), 0);
        check("t5_amt1_done", 32'(done), 1);
        idle(1);
        step(1, 0, c_load, 0, 8'h81, 0, 0);
        step(1, 1, c_rol, 2, 0, 0, 0);
        idle(2);
        check("t5_start_wins", 32'(q), 32'h06);

        // 6: back-to-back start in the done cycle
        step(1, 0, c_load, 0, 8'h2D, 0, 0);
        step(0, 1, c_hold, 2, 0, 0, 0);
        idle(1);
        check("t6_prev_done", 32'(done), 1);
        busy_seen = 0; done_seen = 0;
        step(0, 1, c_shr, 2, 0, 0, 1);
        check("t6_op1", 32'(q), 32'h96);
        step(0, 0, c_hold, 0, 0, 0, 1);
        check("t6_op2", 32'(q), 32'hCB);
        idle(2);
        check("t6_busy_cycles", 32'(busy_seen), 1);
        check("t6_done_cycles", 32'(done_seen), 1);

        // Random mix against the model, including long bursts
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 3'($urandom_range(0, 7)), AMT_W'($urandom_range(0, 15)),
                 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux_shift_reg
`default_nettype wire
